// File: rtl/brick_field_engine.sv
// Brick-breaker playfield: per-brick hit counters, raster-time ball/brick hit detection and game FSM.
// Optional macro BRICK_SCORE_EN adds a saturating 16-bit score counter; otherwise score is tied to 0.
module brick_field_engine #(
  parameter int unsigned ROWS       = 3,
  parameter int unsigned COLS       = 8,
  parameter int unsigned HIT_W      = 2,
  parameter int unsigned BLK_HSTART = 64,
  parameter int unsigned COL_SHIFT  = 6,
  parameter int unsigned BALL_R     = 5,
  parameter int unsigned BOTTOM     = 470,
  localparam int unsigned CNT_W     = $clog2(ROWS*COLS+1)
) (
  input  logic                 pxl_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [9:0]           hcount,
  input  logic [9:0]           vcount,
  input  logic [9:0]           ball_x,
  input  logic [9:0]           ball_y,
  input  logic                 vsync,
  input  logic                 drawing_player,
  input  logic [ROWS-1:0]      drawing_row,
  output logic [ROWS*COLS-1:0] brick_alive,
  output logic [CNT_W-1:0]     bricks_left,
  output logic                 h_collision,
  output logic                 v_collision,
  output logic                 win,
  output logic                 lose,
  output logic [15:0]          score
);

  localparam int unsigned NB    = ROWS * COLS;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned PAD_R = 3;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WIN, S_LOSE} state_e;

  state_e           state_q;
  logic [HIT_W-1:0] hits_q [NB];
  logic [CNT_W-1:0] left_q, load_cnt_c;
  logic             hcol_q, vcol_q, lock_q, win_q, lose_q, vs_q;

  logic [ROW_W-1:0]   row_c;
  logic               row_ok_c;
  logic [COL_W-1:0]   col_c;
  logic [IDX_W-1:0]   idx_c;
  logic signed [10:0] dv_c, dh_c;
  logic [10:0]        adv_c, adh_c;
  logic play_c, alive_c, v_hit_c, h_hit_c, brick_hit_c, last_hit_c;
  logic pad_hit_c, win_now_c, lose_now_c, vs_fall_c;

  function automatic logic [HIT_W-1:0] load_val(input logic [1:0] m, input int unsigned i);
    case (m)
      2'd0:    load_val = HIT_W'(1);
      2'd1:    load_val = (((i / COLS) % 2) == 0) ? HIT_W'(1) : '0;
      2'd2:    load_val = (i == 0) ? HIT_W'(1) : '0;
      default: load_val = '1;
    endcase
  endfunction

  always_comb begin
    case (mode)
      2'd0:    load_cnt_c = CNT_W'(NB);
      2'd1:    load_cnt_c = CNT_W'(((ROWS + 1) / 2) * COLS);
      2'd2:    load_cnt_c = CNT_W'(1);
      default: load_cnt_c = CNT_W'(NB);
    endcase
  end

  // Lowest set row bit addresses the brick row; the column wraps modulo COLS.
  always_comb begin
    row_c    = '0;
    row_ok_c = 1'b0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (drawing_row[r]) begin
        row_c    = ROW_W'(r);
        row_ok_c = 1'b1;
      end
    end
  end

  assign col_c = COL_W'((hcount - 10'(BLK_HSTART)) >> COL_SHIFT);
  assign idx_c = IDX_W'(row_c * COLS + col_c);

  // Signed 11-bit distances keep a ball near a screen edge from wrapping around.
  assign dv_c  = $signed({1'b0, vcount}) - $signed({1'b0, ball_y});
  assign dh_c  = $signed({1'b0, hcount}) - $signed({1'b0, ball_x});
  assign adv_c = dv_c[10] ? $unsigned(-dv_c) : $unsigned(dv_c);
  assign adh_c = dh_c[10] ? $unsigned(-dh_c) : $unsigned(dh_c);

  assign play_c      = (state_q == S_PLAY);
  assign vs_fall_c   = vs_q & ~vsync;
  assign alive_c     = row_ok_c && (hits_q[idx_c] != '0);
  assign v_hit_c     = play_c && !vsync && alive_c && (hcount == ball_x) && (adv_c <= 11'(BALL_R));
  assign h_hit_c     = play_c && !vsync && alive_c && (vcount == ball_y) && (adh_c <= 11'(BALL_R));
  assign brick_hit_c = (v_hit_c || h_hit_c) && !lock_q;
  assign last_hit_c  = (hits_q[idx_c] == HIT_W'(1));
  assign win_now_c   = brick_hit_c && last_hit_c && (left_q == CNT_W'(1));
  assign pad_hit_c   = play_c && drawing_player && (hcount == ball_x) && (adv_c <= 11'(PAD_R));
  assign lose_now_c  = play_c && (ball_y >= 10'(BOTTOM)) && !win_now_c;

  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NB; i++) hits_q[i] <= '0;
      left_q  <= '0;
      hcol_q  <= 1'b0;
      vcol_q  <= 1'b0;
      lock_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      vs_q <= vsync;
      if (vs_fall_c) begin
        hcol_q <= 1'b0;
        vcol_q <= 1'b0;
        lock_q <= 1'b0;
      end
      if (start) begin
        state_q <= S_PLAY;
        for (int i = 0; i < NB; i++) hits_q[i] <= load_val(mode, i);
        left_q  <= load_cnt_c;
        win_q   <= 1'b0;
        lose_q  <= 1'b0;
      end else begin
        if (brick_hit_c) begin
          hits_q[idx_c] <= hits_q[idx_c] - HIT_W'(1);
          lock_q        <= 1'b1;
          if (v_hit_c) vcol_q <= 1'b1;
          else         hcol_q <= 1'b1;
          if (last_hit_c) left_q <= left_q - CNT_W'(1);
        end
        if (pad_hit_c) vcol_q <= 1'b1;
        if (win_now_c) begin
          win_q   <= 1'b1;
          state_q <= S_WIN;
        end else if (lose_now_c) begin
          lose_q  <= 1'b1;
          state_q <= S_LOSE;
        end
      end
    end
  end

  always_comb begin
    brick_alive = '0;
    for (int i = 0; i < NB; i++) brick_alive[i] = |hits_q[i];
  end

  assign bricks_left = left_q;
  assign h_collision = hcol_q;
  assign v_collision = vcol_q;
  assign win         = win_q;
  assign lose        = lose_q;

`ifdef BRICK_SCORE_EN
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;

  // +1 per processed hit, +10 more when that hit clears the brick; saturates.
  always_comb begin
    score_sum = {1'b0, score_q};
    if (brick_hit_c) score_sum = score_sum + (last_hit_c ? 17'd11 : 17'd1);
    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset)      score_q <= '0;
    else if (start) score_q <= '0;
    else            score_q <= score_d;
  end

  assign score = score_q;
`else
  assign score = 16'd0;
`endif

endmodule

// File: tb/tb_brick_field_engine.sv
// Self-checking bench for brick_field_engine: directed game scenarios plus randomized frames
// compared every cycle against a behavioural model of the playfield rules.
module tb_brick_field_engine;

  localparam int ROWS = 3;
  localparam int COLS = 8;
  localparam int NB   = ROWS * COLS;
  localparam int HIT_W = 2;
  localparam int S_IDLE = 0, S_PLAY = 1, S_WIN = 2, S_LOSE = 3;

  logic        pxl_clk = 1'b0;
  logic        reset, start, vsync, drawing_player;
  logic [1:0]  mode;
  logic [9:0]  hcount, vcount, ball_x, ball_y;
  logic [2:0]  drawing_row;
  wire  [23:0] brick_alive;
  wire  [4:0]  bricks_left;
  wire         h_collision, v_collision, win, lose;
  wire  [15:0] score;

  int n_checks = 0;
  int n_fail   = 0;

  int m_hits [NB];
  int m_left, m_state, m_score;
  bit m_h, m_v, m_lock, m_win, m_lose, m_vs;

  brick_field_engine dut (
    .pxl_clk(pxl_clk), .reset(reset), .start(start), .mode(mode),
    .hcount(hcount), .vcount(vcount), .ball_x(ball_x), .ball_y(ball_y),
    .vsync(vsync), .drawing_player(drawing_player), .drawing_row(drawing_row),
    .brick_alive(brick_alive), .bricks_left(bricks_left),
    .h_collision(h_collision), .v_collision(v_collision),
    .win(win), .lose(lose), .score(score)
  );

  always #5 pxl_clk = ~pxl_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_hits[i] = 0;
    m_left = 0; m_state = S_IDLE; m_score = 0;
    m_h = 0; m_v = 0; m_lock = 0; m_win = 0; m_lose = 0; m_vs = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit play = (m_state == S_PLAY);
    bit fall = m_vs && !vsync;
    bit hit = 0, vh = 0, won = 0;
    int row = -1, col, dv, dh, b = 0;
    if (fall) begin m_h = 0; m_v = 0; m_lock = 0; end
    if (start) begin
      m_left = 0;
      for (int i = 0; i < NB; i++) begin
        case (mode)
          2'd0: m_hits[i] = 1;
          2'd1: m_hits[i] = ((i / COLS) % 2 == 0) ? 1 : 0;
          2'd2: m_hits[i] = (i == 0) ? 1 : 0;
          default: m_hits[i] = (1 << HIT_W) - 1;
        endcase
        if (m_hits[i] > 0) m_left++;
      end
      m_state = S_PLAY; m_win = 0; m_lose = 0; m_score = 0;
    end else begin
      for (int r = 0; r < ROWS; r++) if (drawing_row[r] && row < 0) row = r;
      col = (((int'(hcount) - 64 + 1024) % 1024) / 64) % COLS;
      dv = int'(vcount) - int'(ball_y);
      dh = int'(hcount) - int'(ball_x);
      if (play && !vsync && row >= 0 && m_hits[row * COLS + col] > 0) begin
        b   = row * COLS + col;
        vh  = (hcount == ball_x) && (iabs(dv) <= 5);
        hit = !m_lock && (vh || ((vcount == ball_y) && (iabs(dh) <= 5)));
      end
      if (hit) begin
        m_hits[b]--; m_lock = 1; m_score += 1;
        if (vh) m_v = 1; else m_h = 1;
        if (m_hits[b] == 0) begin
          m_left--; m_score += 10;
          if (m_left == 0) begin won = 1; m_win = 1; m_state = S_WIN; end
        end
        if (m_score > 65535) m_score = 65535;
      end
      if (play && drawing_player && (hcount == ball_x) && (iabs(dv) <= 3)) m_v = 1;
      if (play && !won && ball_y >= 470) begin m_lose = 1; m_state = S_LOSE; end
    end
    m_vs = vsync;
  endtask

  task automatic check_all(input string tag);
    logic [23:0] ea;
    int es;
    for (int i = 0; i < NB; i++) ea[i] = (m_hits[i] > 0);
`ifdef BRICK_SCORE_EN
    es = m_score;
`else
    es = 0;
`endif
    check({tag, ".alive"}, 32'(brick_alive), 32'(ea));
    check({tag, ".left"},  32'(bricks_left), 32'(m_left));
    check({tag, ".hcol"},  32'(h_collision), 32'(m_h));
    check({tag, ".vcol"},  32'(v_collision), 32'(m_v));
    check({tag, ".win"},   32'(win),  32'(m_win));
    check({tag, ".lose"},  32'(lose), 32'(m_lose));
    check({tag, ".score"}, 32'(score), 32'(es));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge pxl_clk); #1;
    check_all(tag);
  endtask

  task automatic clear_px();
    start = 0; drawing_row = '0; drawing_player = 0; hcount = '0; vcount = '0;
  endtask

  task automatic do_start(input logic [1:0] m);
    clear_px(); mode = m; start = 1; tick("start"); start = 0;
  endtask

  task automatic frame_start();
    clear_px(); vsync = 1; tick("blank"); tick("blank"); vsync = 0; tick("fall");
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [2:0] row);
    hcount = 10'(h); vcount = 10'(v); drawing_row = row; tick(tag);
  endtask

  initial begin
    int exp_score;
    reset = 1; mode = 0; vsync = 0; ball_x = 10'd200; ball_y = 10'd100;
    clear_px();
    model_reset();
    #12;
    check_all("reset");
    #1 reset = 0;
    @(posedge pxl_clk); #1;

    // Load layout mode 0
    do_start(2'd0);
    check("r37_alive", 32'(brick_alive), 32'h00FF_FFFF);
    check("r37_left", 32'(bricks_left), 32'd24);
    check("r37_win", 32'(win), 32'd0);

    // Three-hit brick at (0,2)
    do_start(2'd3);
    for (int f = 0; f < 3; f++) begin
      frame_start();
      ball_x = 10'd200; ball_y = 10'd100;
      pix("r38", 200, 100, 3'b001);
      check("r38_vcol", 32'(v_collision), 32'd1);
      check("r38_alive2", 32'(brick_alive[2]), (f < 2) ? 32'd1 : 32'd0);
      check("r38_left", 32'(bricks_left), (f < 2) ? 32'd24 : 32'd23);
      clear_px(); tick("r38_idle");
    end

    // Ball overlapping bricks (0,2) and (0,3) on one scan line
    do_start(2'd0);
    frame_start();
    ball_x = 10'd255; ball_y = 10'd100;
    for (int h = 250; h <= 262; h++) pix("r39", h, 100, 3'b001);
    check("r39_alive2", 32'(brick_alive[2]), 32'd0);
    check("r39_alive3", 32'(brick_alive[3]), 32'd1);
    check("r39_left", 32'(bricks_left), 32'd23);
    check("r39_hcol", 32'(h_collision), 32'd1);
    check("r39_vcol", 32'(v_collision), 32'd0);

    // Paddle contact does not take the hit lock
    frame_start();
    ball_x = 10'd200; ball_y = 10'd200;
    drawing_player = 1; pix("pad", 200, 203, 3'b000); drawing_player = 0;
    check("pad_vcol", 32'(v_collision), 32'd1);
    pix("pad_brick", 203, 200, 3'b010);
    check("pad_hcol", 32'(h_collision), 32'd1);
    check("pad_left", 32'(bricks_left), 32'd22);

    // Ball near left edge must not alias to far right
    frame_start();
    ball_x = 10'd2; ball_y = 10'd100;
    pix("edge", 1021, 100, 3'b001);
    check("edge_hcol", 32'(h_collision), 32'd0);
    check("edge_left", 32'(bricks_left), 32'd22);

    // Start and hit in the same cycle: hit discarded
    frame_start();
    ball_x = 10'd200; ball_y = 10'd100;
    mode = 2'd0; start = 1; pix("r32", 200, 100, 3'b001); start = 0;
    check("r32_left", 32'(bricks_left), 32'd24);
    check("r32_vcol", 32'(v_collision), 32'd0);

    // Single-brick layout: one hit wins; bottom afterwards is ignored
    do_start(2'd2);
    frame_start();
    ball_x = 10'd80; ball_y = 10'd100;
    pix("r40", 80, 100, 3'b001);
    check("r40_left", 32'(bricks_left), 32'd0);
    check("r40_win", 32'(win), 32'd1);
    clear_px(); ball_y = 10'd475; tick("r40_bottom");
    check("r40_lose", 32'(lose), 32'd0);
    check("r40_win_hold", 32'(win), 32'd1);

    // Lose at bottom; hits ignored in LOSE; restart with mode 1
    ball_y = 10'd100;
    do_start(2'd0);
    ball_y = 10'd470; tick("r41_bottom");
    check("r41_lose", 32'(lose), 32'd1);
    frame_start();
    ball_x = 10'd200;
    pix("r31", 200, 470, 3'b001);
    check("r31_left", 32'(bricks_left), 32'd24);
    check("r31_vcol", 32'(v_collision), 32'd0);
    ball_y = 10'd100;
    do_start(2'd1);
    check("r41_lose_clr", 32'(lose), 32'd0);
    check("r41_left", 32'(bricks_left), 32'd16);

    // Score: clear two bricks
    do_start(2'd0);
    frame_start();
    ball_x = 10'd200; ball_y = 10'd100; pix("r42a", 200, 100, 3'b001);
    frame_start();
    ball_x = 10'd300; ball_y = 10'd100; pix("r42b", 300, 100, 3'b001);
`ifdef BRICK_SCORE_EN
    exp_score = 22;
`else
    exp_score = 0;
`endif
    check("r42_score", 32'(score), 32'(exp_score));
    check("r42_left", 32'(bricks_left), 32'd22);

    // Reset asserted mid-frame with a live hit pixel
    frame_start();
    ball_x = 10'd200; ball_y = 10'd100;
    hcount = 10'd200; vcount = 10'd100; drawing_row = 3'b010;
    #2 reset = 1;
    #1 model_reset();
    check_all("rst_mid");
    @(posedge pxl_clk); #1;
    check_all("rst_hold");
    #3 reset = 0;
    clear_px();
    @(posedge pxl_clk); #1;

    // Randomized frames
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int fpos;
      int off;
      fpos  = cyc % 24;
      start = ($urandom_range(0, 59) == 0);
      mode  = 2'($urandom_range(0, 3));
      vsync = (fpos < 2);
      if (fpos == 0) begin
        case ($urandom_range(0, 9))
          0:       ball_x = 10'($urandom_range(0, 6));
          1:       ball_x = 10'($urandom_range(1017, 1023));
          default: ball_x = 10'($urandom_range(64, 575));
        endcase
        ball_y = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(465, 480))
                                               : 10'($urandom_range(6, 460));
      end
      if (fpos <= 2) begin
        drawing_row = '0; drawing_player = 0; hcount = '0; vcount = '0;
      end else begin
        off = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 12)) - 6;
        hcount = 10'(int'(ball_x) + off);
        off = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 12)) - 6;
        vcount = 10'(int'(ball_y) + off);
        case ($urandom_range(0, 4))
          0:       drawing_row = 3'b000;
          1:       drawing_row = 3'b010;
          2:       drawing_row = 3'b100;
          default: drawing_row = 3'b001;
        endcase
        drawing_player = ($urandom_range(0, 7) == 0);
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
